// File: rtl/burst_sram_master_if.sv
// Host command/data and memory-side signals of the burst SRAM master.
// The master modport is the block's view; slave is the host-plus-memory side.
interface burst_sram_master_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_we;
    logic [3:0] cmd_addr;
    logic [3:0] cmd_len;
    logic [7:0] wr_data;
    logic       wr_valid;
    logic       wr_ready;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       rd_ready;
    logic       busy;
    logic       done;
    logic       err;
    logic       mem_start;
    logic       mem_we;
    logic [3:0] mem_addr;
    logic [3:0] mem_len;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic       mem_ready;

    modport master (
        input  cmd_valid, cmd_we, cmd_addr, cmd_len,
        input  wr_data, wr_valid, rd_ready,
        input  mem_rdata, mem_ready,
        output cmd_ready, wr_ready, rd_data, rd_valid,
        output busy, done, err,
        output mem_start, mem_we, mem_addr, mem_len, mem_wdata
    );

    modport slave (
        output cmd_valid, cmd_we, cmd_addr, cmd_len,
        output wr_data, wr_valid, rd_ready,
        output mem_rdata, mem_ready,
        input  cmd_ready, wr_ready, rd_data, rd_valid,
        input  busy, done, err,
        input  mem_start, mem_we, mem_addr, mem_len, mem_wdata
    );
endinterface

// File: rtl/burst_sram_master.sv
// Buffers a 1..16 word burst between host and a non-stalling SRAM: START 1 cycle, XFER N, WAIT 1.
// Host write/read words use valid/ready and may stall LOAD/DRAIN indefinitely; XFER never waits.
module burst_sram_master (
    input  logic clk,
    input  logic rst,
    burst_sram_master_if.master bus
);
    typedef enum logic [2:0] {IDLE, LOAD, START, XFER, WAIT, DRAIN} state_t;

    state_t     state, state_nxt;
    logic [4:0] n_q;
    logic [4:0] cnt_q;
    logic       we_q;
    logic [3:0] addr_q;
    logic [3:0] len_q;
    logic       live_q;
    logic       err_q;
    logic       done_q;
    logic       done_set;
    logic [7:0] mem_buf [16];

    logic       cmd_acc;
    logic       wr_acc;
    logic       rd_acc;
    logic       cnt_last;
    logic [3:0] cap_idx;

    assign bus.cmd_ready = live_q && (state == IDLE);
    assign bus.wr_ready  = (state == LOAD);
    assign bus.rd_valid  = (state == DRAIN);
    assign bus.rd_data   = (state == DRAIN) ? mem_buf[cnt_q[3:0]] : 8'h00;
    assign bus.busy      = (state != IDLE);
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.mem_start = (state == START);
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_len   = len_q;
    assign bus.mem_wdata = (state == XFER && we_q) ? mem_buf[cnt_q[3:0]] : 8'h00;

    assign cmd_acc  = bus.cmd_valid && bus.cmd_ready;
    assign wr_acc   = bus.wr_valid && (state == LOAD);
    assign rd_acc   = bus.rd_ready && (state == DRAIN);
    assign cnt_last = (cnt_q == n_q - 5'd1);
    // Read word k lands one cycle late: XFER cycle k+1, or WAIT for the last word.
    assign cap_idx  = (state == WAIT) ? (n_q[3:0] - 4'd1) : (cnt_q[3:0] - 4'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        done_set  = 1'b0;
        case (state)
            IDLE:  if (cmd_acc) state_nxt = bus.cmd_we ? LOAD : START;
            LOAD:  if (wr_acc && cnt_last) state_nxt = START;
            START: state_nxt = XFER;
            XFER:  if (cnt_last) state_nxt = WAIT;
            WAIT: begin
                if (!bus.mem_ready) begin
                    state_nxt = IDLE;
                end else if (we_q) begin
                    state_nxt = IDLE;
                    done_set  = 1'b1;
                end else begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (rd_acc && cnt_last) begin
                    state_nxt = IDLE;
                    done_set  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            live_q <= 1'b0;
            we_q   <= 1'b0;
            addr_q <= 4'd0;
            len_q  <= 4'd0;
            n_q    <= 5'd0;
            cnt_q  <= 5'd0;
            err_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            live_q <= 1'b1;
            done_q <= done_set;
            if (cmd_acc) begin
                we_q   <= bus.cmd_we;
                addr_q <= bus.cmd_addr;
                len_q  <= bus.cmd_len;
                n_q    <= (bus.cmd_len == 4'd0) ? 5'd16 : {1'b0, bus.cmd_len};
            end
            // One counter serves as k (LOAD), i (XFER) and j (DRAIN); it restarts on every state change.
            if (state_nxt != state)
                cnt_q <= 5'd0;
            else if (wr_acc || (state == XFER) || rd_acc)
                cnt_q <= cnt_q + 5'd1;
            if (cmd_acc)
                err_q <= 1'b0;
            else if ((state == XFER && bus.mem_ready) || (state == WAIT && !bus.mem_ready))
                err_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc)
            mem_buf[cnt_q[3:0]] <= bus.wr_data;
        else if (!we_q && ((state == XFER && cnt_q != 5'd0) || state == WAIT))
            mem_buf[cap_idx] <= bus.mem_rdata;
    end
endmodule

// File: doc/burst_sram_master.md
BURST_SRAM_MASTER -- requirements
Module: burst_sram_master

Interface
REQ-001 The block SHALL have no parameters; the address width is fixed at 4 bits and the data width at 8 bits.
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset, with ports as follows:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
REQ-003 The host command ports SHALL be:
- cmd_valid  in  1  command request.
- cmd_ready  out  1  block accepts a command.
- cmd_we  in  1  1=write burst, 0=read burst.
- cmd_addr  in  4  start address.
- cmd_len  in  4  word count; 0 means 16 words.
REQ-004 The host write-data ports SHALL be:
- wr_data  in  8  write data.
- wr_valid  in  1  write word offered.
- wr_ready  out  1  write word accepted.
REQ-005 The host read-data ports SHALL be:
- rd_data  out  8  read data.
- rd_valid  out  1  read word offered.
- rd_ready  in  1  host accepts the read word.
REQ-006 The status ports SHALL be:
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  protocol error, sticky.
REQ-007 The memory-side ports SHALL be:
- mem_start  out  1  burst start.
- mem_we  out  1  write enable.
- mem_addr  out  4  start address.
- mem_len  out  4  burst length, raw cmd_len.
- mem_wdata  out  8  write data to the memory.
- mem_rdata  in  8  registered read data from the memory.
- mem_ready  in  1  memory burst-complete pulse.

Function
REQ-008 The block SHALL implement states IDLE, LOAD, START, XFER, WAIT and DRAIN.
REQ-009 The word count SHALL be N = 16 when cmd_len == 0, otherwise N = cmd_len; N SHALL be held in a 5-bit register.
REQ-010 In IDLE, cmd_ready SHALL be 1.
REQ-011 On cmd_valid && cmd_ready, the block SHALL latch cmd_we, cmd_addr, cmd_len and N, and SHALL clear err.
REQ-012 After command acceptance, the next state SHALL be LOAD if cmd_we=1, else START.
REQ-013 In LOAD, wr_ready SHALL be 1.
REQ-014 In LOAD, each wr_valid && wr_ready SHALL store wr_data into internal buffer entry k, with k counting 0..N-1.
REQ-015 After the N-th accepted write word the state SHALL move to START; LOAD SHALL wait indefinitely with no timeout.
REQ-016 The memory cannot stall, so no XFER cycle SHALL depend on any host handshake.
REQ-017 START SHALL last exactly 1 cycle with mem_start=1; mem_start SHALL be 0 in every other state.
REQ-018 mem_we, mem_addr and mem_len SHALL be driven from the latched command and held stable from START through WAIT.
REQ-019 XFER SHALL last exactly N cycles, indexed i = 0..N-1, and then move to WAIT.
REQ-020 In XFER cycle i of a write, mem_wdata SHALL equal buf[i]; outside XFER, mem_wdata SHALL be 0.
REQ-021 Read word k SHALL appear on mem_rdata during XFER cycle k+1 for k < N-1, and during the WAIT cycle for k = N-1.
REQ-022 On a read, the block SHALL capture each read word into buf[k] at the clock edge ending that cycle.
REQ-023 WAIT SHALL last exactly 1 cycle, in which mem_ready=1 is expected.
REQ-024 If mem_ready=1 in WAIT on a write, the next state SHALL be IDLE and done SHALL pulse in the following cycle.
REQ-025 If mem_ready=1 in WAIT on a read, the next state SHALL be DRAIN.
REQ-026 If mem_ready=0 in WAIT, err SHALL be set to 1, the next state SHALL be IDLE, done SHALL NOT pulse, and the buffer contents SHALL NOT be drained.
REQ-027 If mem_ready=1 in any XFER cycle, err SHALL be set to 1; the sequence SHALL continue unchanged.
REQ-028 In DRAIN, rd_valid SHALL be 1 and rd_data SHALL equal buf[j], with j counting 0..N-1.
REQ-029 In DRAIN, j SHALL advance on rd_valid && rd_ready, and rd_data SHALL hold stable while rd_ready=0.
REQ-030 After the N-th read word is accepted, the state SHALL move to IDLE and done SHALL pulse in the following cycle.
REQ-031 rd_valid SHALL be 0 outside DRAIN.
REQ-032 wr_ready SHALL be 0 outside LOAD.
REQ-033 cmd_ready SHALL be 0 outside IDLE.
REQ-034 cmd_valid outside IDLE SHALL be ignored and SHALL NOT be queued.
REQ-035 The memory-side address SHALL wrap with 4-bit arithmetic; for example, cmd_addr=14 with N=4 covers addresses 14, 15, 0, 1, all handled by the memory.
REQ-036 All outputs SHALL be registered or decoded from registered state only, with no combinational path from inputs to outputs.
REQ-037 busy SHALL be 1 in every state other than IDLE.

Reset
REQ-038 While rst=1, the state SHALL be IDLE and the counters i, j and k SHALL be 0.
REQ-039 While rst=1, the following outputs SHALL be 0: mem_start, mem_we, mem_addr, mem_len, mem_wdata, rd_data, rd_valid, wr_ready, done, err and busy.
REQ-040 While rst=1, cmd_ready SHALL be 0; it SHALL become 1 in the first cycle after rst deasserts.
REQ-041 Reset asserted mid-burst SHALL abort immediately, and no done pulse SHALL follow.
REQ-042 The buffer contents SHALL NOT be reset.

Verification
REQ-043 Write then read, with a behavioural memory model attached:
- write addr=3, len=4, data A0..A3, then read addr=3, len=4 with rd_ready=1 -> rd_data A0, A1, A2, A3 in order, one done per command, err=0.
REQ-044 Length zero -> write addr=0, len=0 with 16 words 0x00..0x0F -> XFER lasts 16 cycles; a read of the same range returns 0x00..0x0F.
REQ-045 Address wrap -> write addr=14, len=4 (0x11, 0x22, 0x33, 0x44) -> memory locations 14, 15, 0, 1 hold those values.
REQ-046 Back-pressure -> read len=3 with rd_ready toggling 1,0,0,1,... -> rd_data stable while stalled; exactly 3 words delivered, no loss or duplication.
REQ-047 Protocol fault -> mem_ready tied 0 -> err=1 after WAIT, return to IDLE, no done, no rd_valid; the next accepted command clears err.
REQ-048 Reset mid-operation -> rst asserted in XFER cycle 2 -> mem_start=0, busy=0 and cmd_ready=0 during reset; cmd_ready=1 in the first cycle after release; no done pulse.
